counter_timer_ctrl: RTL

//   Bus-programmable controller placed directly upstream of the 32-bit up/down counter.

---
 rtl/counter_timer_ctrl_pkg.sv | 30 +++
 rtl/counter_timer_ctrl_regs.sv | 74 +++++++
 rtl/counter_timer_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/counter_timer_ctrl_pkg.sv
// Shared definitions for the counter timer controller: register map, CTRL layout, FSM states.
package counter_timer_ctrl_pkg;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPeriod = 2'd1;
    localparam logic [1:0] AddrStatus = 2'd2;
    localparam logic [1:0] AddrCount  = 2'd3;

    localparam int unsigned CtrlEn    = 0;
    localparam int unsigned CtrlRel   = 1;
    localparam int unsigned CtrlDir   = 2;
    localparam int unsigned CtrlIrqEn = 3;
    localparam int unsigned CtrlW     = 4;

    // Field order matches the CTRL bit positions above (msb first).
    typedef struct packed {
        logic irq_en;
        logic dir;
        logic reload;
        logic en;
    } ctrl_t;

    typedef enum logic [1:0] {
        StStop = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/counter_timer_ctrl_regs.sv
// Bus-visible registers: CTRL, PERIOD, sticky STATUS.expired and the read-data mux.
module counter_timer_ctrl_regs
    import counter_timer_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [CNT_W-1:0] cnt_value,
    input  logic             set_expired,
    output logic [CNT_W-1:0] rdata,
    output ctrl_t            ctrl,
    output logic [CNT_W-1:0] period,
    output logic             expired,
    output logic             ctrl_wr
);

    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] period_q;
    logic             expired_q;
    logic             expired_d;
    logic             period_wr;
    logic             status_clr;

    assign ctrl_wr    = we && (addr == AddrCtrl);
    assign period_wr  = we && (addr == AddrPeriod);
    assign status_clr = we && (addr == AddrStatus) && wdata[0];

    // A set in the same cycle as a clear must win so no expiry is lost.
    always_comb begin
        expired_d = expired_q;
        if (status_clr) begin
            expired_d = 1'b0;
        end
        if (set_expired) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            period_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_q <= ctrl_t'(wdata[CtrlW-1:0]);
            end
            if (period_wr) begin
                period_q <= wdata;
            end
            expired_q <= expired_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            AddrCtrl:   rdata = {{(CNT_W-CtrlW){1'b0}}, ctrl_q};
            AddrPeriod: rdata = period_q;
            AddrStatus: rdata = {{(CNT_W-1){1'b0}}, expired_q};
            AddrCount:  rdata = cnt_value;
            default:    rdata = '0;
        endcase
    end

    assign ctrl    = ctrl_q;
    assign period  = period_q;
    assign expired = expired_q;

endmodule

// File: rtl/counter_timer_ctrl.sv
// Timer controller driving an external up/down counter's Load/PData/s and watching its Rc flag.
module counter_timer_ctrl
    import counter_timer_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata,
    output logic             irq,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_pdata,
    output logic             cnt_dir,
    input  logic [CNT_W-1:0] cnt_value,
    input  logic             cnt_rc
);

    state_e           state_q;
    state_e           state_d;
    logic             rc_mask_q;
    logic [CNT_W-1:0] hold_q;
    logic             set_expired;
    logic             ctrl_wr;
    logic             expired;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] period;

    counter_timer_ctrl_regs #(
        .CNT_W (CNT_W)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .cnt_value   (cnt_value),
        .set_expired (set_expired),
        .rdata       (rdata),
        .ctrl        (ctrl),
        .period      (period),
        .expired     (expired),
        .ctrl_wr     (ctrl_wr)
    );

    // Rc is only trusted once the first post-load cycle has passed.
    assign set_expired = (state_q == StRun) && !rc_mask_q && cnt_rc;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStop: state_d = StStop;
            StLoad: state_d = StRun;
            StRun: begin
                if (set_expired) begin
                    state_d = ctrl.reload ? StLoad : StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StStop;
        endcase
        // Any CTRL write overrides the local transition.
        if (ctrl_wr) begin
            state_d = wdata[CtrlEn] ? StLoad : StStop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StStop;
            rc_mask_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            rc_mask_q <= (state_q == StLoad);
            if ((state_d == StStop || state_d == StDone) && (state_d != state_q)) begin
                hold_q <= cnt_value;
            end
        end
    end

    always_comb begin
        cnt_load  = 1'b1;
        cnt_pdata = hold_q;
        cnt_dir   = 1'b0;
        unique case (state_q)
            StStop: begin
                cnt_load  = 1'b1;
                cnt_pdata = hold_q;
            end
            StLoad: begin
                cnt_load  = 1'b1;
                cnt_pdata = ctrl.dir ? ({CNT_W{1'b1}} - period) : period;
            end
            StRun: begin
                cnt_load = 1'b0;
                cnt_dir  = ctrl.dir;
            end
            StDone: begin
                cnt_load  = 1'b1;
                cnt_pdata = hold_q;
            end
            default: begin
                cnt_load  = 1'b1;
                cnt_pdata = hold_q;
            end
        endcase
    end

    assign irq = expired & ctrl.irq_en;

endmodule
